// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Serves byte/half/word loads and stores over a req/done handshake.
// The access latency is set by LATENCY.
//
// Ports
//   clk_i        clock, rising edge
//   start_i      asynchronous active-low reset
//   req_i        request valid, sampled only while IDLE
//   addr_i       byte address
//   MemRead_i    read access code  (0 none, 1 byte, 2 half, 3 word)
//   MemWrite_i   write access code (0 none, 1 byte, 2 half, 3 word)
//   WriteData_i  store data, right-justified
//   busy_o       request in flight
//   done_o       one-cycle completion pulse
//   err_o        error qualifier, valid with done_o
//   ReadData_o   load result, held until the next read or error completion
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request with a non-zero access code
// WAIT  | request latched; latency down-counter running, access at zero

module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  MemRead_i,
    input  logic [1:0]  MemWrite_i,
    input  logic [31:0] WriteData_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] ReadData_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, stateNext;
    logic [3:0]  cnt, cntNext;
    logic [31:0] addrQ, wdQ;
    logic [1:0]  rdQ, wrQ;

    logic        busyNext, doneNext, errNext;
    logic [31:0] readNext;
    logic        accept, memWe, accErr;
    logic [1:0]  code;
    logic [AW-1:0] wordIdx;
    logic [4:0]  byteShift, halfShift;
    logic [31:0] curWord, laneMask, laneData, mergedWord, loadVal;

    logic [31:0] mem [DEPTH];

    // Access decode on the latched request.
    always_comb begin
        accept    = (state == IDLE) && req_i && ((MemRead_i != 2'd0) || (MemWrite_i != 2'd0));
        code      = (rdQ != 2'd0) ? rdQ : wrQ;
        wordIdx   = addrQ[AW+1:2];
        curWord   = mem[wordIdx];
        byteShift = {addrQ[1:0], 3'b000};
        halfShift = {addrQ[1], 4'b0000};

        accErr = ((rdQ != 2'd0) && (wrQ != 2'd0))
              || ((code == 2'd2) && addrQ[0])
              || ((code == 2'd3) && (addrQ[1:0] != 2'b00))
              || ({2'b00, addrQ[31:2]} >= 32'(DEPTH));

        case (code)
            2'd1: begin
                laneMask = 32'h0000_00FF << byteShift;
                laneData = {24'h0, wdQ[7:0]} << byteShift;
                loadVal  = (curWord >> byteShift) & 32'h0000_00FF;
            end
            2'd2: begin
                laneMask = 32'h0000_FFFF << halfShift;
                laneData = {16'h0, wdQ[15:0]} << halfShift;
                loadVal  = (curWord >> halfShift) & 32'h0000_FFFF;
            end
            default: begin
                laneMask = 32'hFFFF_FFFF;
                laneData = wdQ;
                loadVal  = curWord;
            end
        endcase

        // Read-modify-write keeps the unaddressed lanes of the word.
        mergedWord = (curWord & ~laneMask) | (laneData & laneMask);
    end

    // Next-state and output logic.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        busyNext  = busy_o;
        doneNext  = 1'b0;
        errNext   = 1'b0;
        readNext  = ReadData_o;
        memWe     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = WAIT;
                    cntNext   = 4'(LATENCY - 1);
                    busyNext  = 1'b1;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                    doneNext  = 1'b1;
                    if (accErr) begin
                        errNext  = 1'b1;
                        readNext = 32'h0;
                    end else if (rdQ != 2'd0) begin
                        readNext = loadVal;
                    end else begin
                        memWe = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            ReadData_o <= 32'h0;
            addrQ      <= 32'h0;
            wdQ        <= 32'h0;
            rdQ        <= 2'd0;
            wrQ        <= 2'd0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            busy_o     <= busyNext;
            done_o     <= doneNext;
            err_o      <= errNext;
            ReadData_o <= readNext;
            if (accept) begin
                addrQ <= addr_i;
                wdQ   <= WriteData_i;
                rdQ   <= MemRead_i;
                wrQ   <= MemWrite_i;
            end
        end
    end

    // Storage is never reset. memWe can only be high in WAIT, so a reset
    // that lands mid-request drops the pending store.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem[wordIdx] <= mergedWord;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        start_i = 1'b0;
    logic        reqA = 1'b0, reqB = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [1:0]  rd = 2'd0, wr = 2'd0;

    logic        busyA, doneA, errA, busyB, doneB, errB;
    logic [31:0] rdataA, rdataB;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dutA (
        .clk_i(clk_i), .start_i(start_i), .req_i(reqA), .addr_i(addr),
        .MemRead_i(rd), .MemWrite_i(wr), .WriteData_i(wdata),
        .busy_o(busyA), .done_o(doneA), .err_o(errA), .ReadData_o(rdataA)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dutB (
        .clk_i(clk_i), .start_i(start_i), .req_i(reqB), .addr_i(addr),
        .MemRead_i(rd), .MemWrite_i(wr), .WriteData_i(wdata),
        .busy_o(busyB), .done_o(doneB), .err_o(errB), .ReadData_o(rdataB)
    );

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    // Byte-addressed reference memory per instance plus expected ReadData.
    logic [7:0]  refMem [2][DEPTH*4];
    logic [31:0] expRd [2];
    int          lastDone;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current negedge, hold req until done, check it.
    task automatic runTxn(input int sel, input logic [1:0] r, input logic [1:0] w,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        int          lat;
        int          code;
        int          nb;
        bit          expErr;
        logic [31:0] val;
        int          n;
        bit          busyOk;
        bit          seen;
        lat    = (sel != 0) ? 1 : 2;
        code   = (r != 2'd0) ? int'(r) : int'(w);
        nb     = (code == 1) ? 1 : (code == 2) ? 2 : 4;
        expErr = ((r != 2'd0) && (w != 2'd0)) || (code == 2 && (a % 2) != 0)
              || (code == 3 && (a % 4) != 0) || ((a / 4) >= DEPTH);
        val    = 32'h0;
        n      = 0;
        busyOk = 1'b1;
        seen   = 1'b0;
        if (expErr) begin
            expRd[sel] = 32'h0;
        end else if (r != 2'd0) begin
            for (int i = 0; i < nb; i++) val = val | (32'(refMem[sel][a + i]) << (8 * i));
            expRd[sel] = val;
        end else begin
            for (int i = 0; i < nb; i++) refMem[sel][a + i] = d[8*i +: 8];
        end

        addr = a; rd = r; wr = w; wdata = d;
        if (sel != 0) reqB = 1'b1; else reqA = 1'b1;
        @(posedge clk_i);
        while (!seen && n < 20) begin
            @(negedge clk_i);
            n++;
            if ((sel != 0) ? doneB : doneA) seen = 1'b1;
            else if (!((sel != 0) ? busyB : busyA)) busyOk = 1'b0;
        end
        check({tag, " latency"}, 32'(n), 32'(lat + 1));
        check({tag, " busy_wait"}, {31'h0, busyOk}, 32'h1);
        if (seen) begin
            lastDone = cyc;
            check({tag, " err"}, {31'h0, (sel != 0) ? errB : errA}, {31'h0, expErr});
            check({tag, " rdata"}, (sel != 0) ? rdataB : rdataA, expRd[sel]);
            check({tag, " busy_done"}, {31'h0, (sel != 0) ? busyB : busyA}, 32'h0);
        end
        reqA = 1'b0; reqB = 1'b0; rd = 2'd0; wr = 2'd0;
    endtask

    // Watch a few cycles with no request pending: no done, no busy.
    task automatic idleCheck(input int sel, input int cycles, input string tag);
        bit quiet;
        quiet = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if ((sel != 0) ? (doneB | busyB | errB) : (doneA | busyA | errA)) quiet = 1'b0;
        end
        check({tag, " idle"}, {31'h0, quiet}, 32'h1);
    endtask

    initial begin
        int          t0;
        int          kind;
        logic [1:0]  rc, wc;
        logic [31:0] ra;
        expRd[0] = 32'h0;
        expRd[1] = 32'h0;

        #1;
        check("reset busy", {31'h0, busyA}, 32'h0);
        check("reset done", {31'h0, doneA}, 32'h0);
        check("reset err", {31'h0, errA}, 32'h0);
        check("reset rdata", rdataA, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 16; i++) runTxn(0, 2'd0, 2'd3, 32'(i * 4), $urandom, "init");
        idleCheck(0, 2, "init");

        runTxn(0, 2'd0, 2'd3, 32'h20, 32'h1234_5678, "wr_word");
        idleCheck(0, 3, "after_wr");
        runTxn(0, 2'd3, 2'd0, 32'h20, 32'h0, "rd_word");
        runTxn(0, 2'd0, 2'd1, 32'h21, 32'h0000_00AA, "wr_byte");
        runTxn(0, 2'd3, 2'd0, 32'h20, 32'h0, "rd_merged");
        check("merged value", rdataA, 32'h1234_AA78);
        runTxn(0, 2'd1, 2'd0, 32'h23, 32'h0, "rd_byte");
        check("byte value", rdataA, 32'h0000_0012);
        runTxn(0, 2'd2, 2'd0, 32'h22, 32'h0, "rd_half");
        check("half value", rdataA, 32'h0000_1234);
        runTxn(0, 2'd2, 2'd0, 32'h21, 32'h0, "half_misalign");
        runTxn(0, 2'd0, 2'd3, 32'h22, 32'hFFFF_FFFF, "word_wr_misalign");
        runTxn(0, 2'd3, 2'd0, 32'h20, 32'h0, "rd_unchanged");
        runTxn(0, 2'd3, 2'd0, 32'(DEPTH * 4), 32'h0, "rd_range");
        runTxn(0, 2'd3, 2'd1, 32'h20, 32'h0, "rd_wr_both");
        idleCheck(0, 4, "after_err");

        // Back-to-back: second request issued in the done cycle.
        runTxn(0, 2'd3, 2'd0, 32'h04, 32'h0, "b2b_first");
        t0 = lastDone;
        runTxn(0, 2'd3, 2'd0, 32'h08, 32'h0, "b2b_second");
        check("b2b spacing", 32'(lastDone - t0), 32'd3);
        idleCheck(0, 2, "after_b2b");

        // Request with both codes zero is ignored.
        reqA = 1'b1; rd = 2'd0; wr = 2'd0; addr = 32'h20;
        idleCheck(0, 5, "zero_codes");
        reqA = 1'b0;

        // Reset in the middle of a store aborts it.
        runTxn(0, 2'd0, 2'd3, 32'h10, 32'hCAFE_0001, "pre_reset_wr");
        runTxn(0, 2'd3, 2'd0, 32'h10, 32'h0, "pre_reset_rd");
        addr = 32'h10; wr = 2'd3; rd = 2'd0; wdata = 32'hDEAD_BEEF; reqA = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        check("mid_wait busy", {31'h0, busyA}, 32'h1);
        start_i = 1'b0;
        #1;
        check("abort busy", {31'h0, busyA}, 32'h0);
        check("abort done", {31'h0, doneA}, 32'h0);
        check("abort err", {31'h0, errA}, 32'h0);
        check("abort rdata", rdataA, 32'h0);
        reqA = 1'b0; wr = 2'd0;
        expRd[0] = 32'h0;
        expRd[1] = 32'h0;
        @(negedge clk_i);
        start_i = 1'b1;
        idleCheck(0, 2, "post_reset");
        runTxn(0, 2'd3, 2'd0, 32'h10, 32'h0, "post_reset_rd");
        check("abort kept", rdataA, 32'hCAFE_0001);

        // Randomized traffic against the byte-level model.
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(9));
            rc = 2'($urandom_range(3, 1));
            wc = 2'($urandom_range(3, 1));
            if ($urandom_range(9) == 0) ra = 32'(DEPTH * 4) + 32'($urandom_range(255));
            else ra = 32'($urandom_range(63));
            if (kind == 0) runTxn(0, rc, wc, ra, $urandom, "rand_both");
            else if (kind < 5) runTxn(0, rc, 2'd0, ra, $urandom, "rand_rd");
            else runTxn(0, 2'd0, wc, ra, $urandom, "rand_wr");
            if ($urandom_range(1) == 1) @(negedge clk_i);
        end

        // LATENCY=1 instance: fill four words, then stream reads.
        idleCheck(1, 2, "b_start");
        for (int i = 0; i < 4; i++) runTxn(1, 2'd0, 2'd3, 32'(i * 4), $urandom, "b_init");
        idleCheck(1, 2, "b_init");
        runTxn(1, 2'd3, 2'd0, 32'h0, 32'h0, "b_rd0");
        for (int i = 1; i < 4; i++) begin
            t0 = lastDone;
            runTxn(1, 2'd3, 2'd0, 32'(i * 4), 32'h0, "b_rd");
            check("b spacing", 32'(lastDone - t0), 32'd2);
        end
        idleCheck(1, 2, "b_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
